// File: rtl/rtc_set_controller.sv
// ---------------------------------------------------------------------------
// rtc_set_controller
//
// Real-time clock (hh:mm:ss) that can be set with two debounced keys.
//
// key_mode steps the mode: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN.
// In a SET mode, key_inc increments the selected field. Each field wraps
// on its own and does not carry into the other fields. In RUN, the time
// advances once per TICK_DIV clock cycles.
//
// Ports
//   CLOCK_50   in   1  sole clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   key_mode   in   1  debounced level; each rising edge advances the mode
//   key_inc    in   1  debounced level; each rising edge bumps the field
//   hour       out  5  0..23
//   min        out  6  0..59
//   sec        out  6  0..59
//   mode       out  2  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   blink      out  1  blink enable for the selected field (0 in RUN)
//   sec_pulse  out  1  one-cycle strobe with each second increment in RUN
// ---------------------------------------------------------------------------
module rtc_set_controller #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_pulse
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC_MAX  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] TC_HALF = CW'(TICK_DIV / 2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] tcnt;
    logic [CW-1:0] tcnt_next;
    logic          key_mode_q;
    logic          key_inc_q;
    logic          mode_edge;
    logic          inc_edge;
    logic          tick;
    logic [4:0]    hour_next;
    logic [5:0]    min_next;
    logic [5:0]    sec_next;
    logic          blink_next;
    logic          sec_pulse_next;

    // Hour increment with wrap. Any value at or above 23 returns to 0, so
    // the hour stays in range even if it ever held an illegal value.
    function automatic logic [4:0] inc_hour(input logic [4:0] v);
        logic [4:0] r;
        if (v >= 5'd23) begin
            r = 5'd0;
        end else begin
            r = v + 5'd1;
        end
        return r;
    endfunction

    // Minute/second increment with wrap at 59. Values above 59 also
    // collapse to 0.
    function automatic logic [5:0] inc_sixty(input logic [5:0] v);
        logic [5:0] r;
        if (v >= 6'd59) begin
            r = 6'd0;
        end else begin
            r = v + 6'd1;
        end
        return r;
    endfunction

    assign mode_edge = key_mode & ~key_mode_q;
    assign inc_edge  = key_inc & ~key_inc_q;
    assign tick      = (tcnt == TC_MAX);
    assign mode      = state;

    // Next mode: each key_mode edge steps once around the ring.
    always_comb begin
        state_next = state;
        if (mode_edge) begin
            case (state)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                SET_SEC:  state_next = RUN;
                default:  state_next = RUN;
            endcase
        end else begin
            state_next = state;
        end
    end

    // Next tick counter, time fields, pulse and blink.
    always_comb begin
        hour_next      = hour;
        min_next       = min;
        sec_next       = sec;
        sec_pulse_next = 1'b0;

        // The counter is free-running. Leaving SET_SEC restarts it, so the
        // first second after setting lasts a full TICK_DIV cycles.
        if ((state == SET_SEC) && mode_edge) begin
            tcnt_next = '0;
        end else if (tick) begin
            tcnt_next = '0;
        end else begin
            tcnt_next = tcnt + CW'(1);
        end

        // A simultaneous key_mode edge overrides key_inc, so a field bump is
        // taken only when key_inc has an edge and key_mode does not.
        case (state)
            RUN: begin
                if (tick) begin
                    sec_pulse_next = 1'b1;
                    sec_next       = inc_sixty(sec);
                    if (sec >= 6'd59) begin
                        min_next = inc_sixty(min);
                        if (min >= 6'd59) begin
                            hour_next = inc_hour(hour);
                        end else begin
                            hour_next = hour;
                        end
                    end else begin
                        min_next = min;
                    end
                end else begin
                    sec_pulse_next = 1'b0;
                end
            end
            SET_HOUR: begin
                if (inc_edge && !mode_edge) begin
                    hour_next = inc_hour(hour);
                end else begin
                    hour_next = hour;
                end
            end
            SET_MIN: begin
                if (inc_edge && !mode_edge) begin
                    min_next = inc_sixty(min);
                end else begin
                    min_next = min;
                end
            end
            SET_SEC: begin
                if (inc_edge && !mode_edge) begin
                    sec_next = inc_sixty(sec);
                end else begin
                    sec_next = sec;
                end
            end
            default: begin
                sec_pulse_next = 1'b0;
            end
        endcase

        // Blink is registered from the next mode and counter values, so the
        // output always matches the current mode and tcnt.
        blink_next = (state_next != RUN) && (tcnt_next >= TC_HALF);
    end

    // Mode state register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: key history, tick counter, time fields and strobes.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            key_mode_q <= 1'b0;
            key_inc_q  <= 1'b0;
            tcnt       <= '0;
            hour       <= 5'd0;
            min        <= 6'd0;
            sec        <= 6'd0;
            blink      <= 1'b0;
            sec_pulse  <= 1'b0;
        end else begin
            key_mode_q <= key_mode;
            key_inc_q  <= key_inc;
            tcnt       <= tcnt_next;
            hour       <= hour_next;
            min        <= min_next;
            sec        <= sec_next;
            blink      <= blink_next;
            sec_pulse  <= sec_pulse_next;
        end
    end

endmodule

// File: tb/tb_rtc_set_controller.sv
// ---------------------------------------------------------------------------
// tb_rtc_set_controller
//
// Directed, self-checking bench for rtc_set_controller with TICK_DIV=4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at
// that same point.
// ---------------------------------------------------------------------------
module tb_rtc_set_controller;

    logic       clk;
    logic       rst;
    logic       key_mode;
    logic       key_inc;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       blink;
    logic       sec_pulse;

    int checks;
    int errors;
    int cyc;
    logic pulse_seen;

    rtc_set_controller #(.TICK_DIV(4)) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .mode      (mode),
        .blink     (blink),
        .sec_pulse (sec_pulse)
    );

    // Clock: 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock. cyc tracks the tick counter phase since reset.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        pulse_seen = pulse_seen | sec_pulse;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cyc = 0;
        pulse_seen = 1'b0;
    endtask

    task automatic press_mode();
        key_mode = 1'b1;
        step();
        key_mode = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            key_inc = 1'b1;
            step();
            key_inc = 1'b0;
            step();
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        pulse_seen = 1'b0;
        rst        = 1'b1;
        key_mode   = 1'b0;
        key_inc    = 1'b0;

        // Reset state while rst is held.
        step();
        step();
        check_val("rst_hour", hour, 0);
        check_val("rst_min", min, 0);
        check_val("rst_sec", sec, 0);
        check_val("rst_mode", mode, 0);
        check_val("rst_blink", blink, 0);
        check_val("rst_pulse", sec_pulse, 0);

        // First tick arrives on the 4th clock after release.
        do_reset();
        step();
        step();
        step();
        check_val("pre_tick_sec", sec, 0);
        check_val("pre_tick_pulse", sec_pulse, 0);
        step();
        check_val("tick1_sec", sec, 1);
        check_val("tick1_pulse", sec_pulse, 1);
        check_val("run_blink", blink, 0);
        step();
        check_val("tick1_pulse_end", sec_pulse, 0);

        // key_inc is ignored in RUN (cyc 5..7, before the next tick).
        press_inc(1);
        check_val("run_inc_sec", sec, 1);
        check_val("run_inc_min", min, 0);
        check_val("run_inc_hour", hour, 0);

        // Set 23:59:59, return to RUN, then roll over after 4 cycles.
        do_reset();
        press_mode();
        check_val("set_mode_hour", mode, 1);
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        check_val("set_mode_sec", mode, 3);
        press_inc(59);
        check_val("set_hour23", hour, 23);
        check_val("set_min59", min, 59);
        check_val("set_sec59", sec, 59);
        check_val("set_no_pulse", pulse_seen, 0);
        key_mode = 1'b1;
        step();
        key_mode = 1'b0;
        check_val("back_run_mode", mode, 0);
        check_val("back_run_blink", blink, 0);
        check_val("back_run_sec", sec, 59);
        step();
        step();
        step();
        check_val("rollover_wait_sec", sec, 59);
        check_val("rollover_wait_pulse", sec_pulse, 0);
        step();
        check_val("rollover_hour", hour, 0);
        check_val("rollover_min", min, 0);
        check_val("rollover_sec", sec, 0);
        check_val("rollover_pulse", sec_pulse, 1);
        step();
        check_val("rollover_pulse_end", sec_pulse, 0);

        // SET_HOUR wrap: 24 presses return to 0; the other fields are untouched.
        do_reset();
        for (int i = 0; i < 4; i++) step();
        press_mode();
        pulse_seen = 1'b0;
        check_val("sh_mode", mode, 1);
        press_inc(23);
        check_val("sh_hour23", hour, 23);
        press_inc(1);
        check_val("sh_hour_wrap", hour, 0);
        check_val("sh_min", min, 0);
        check_val("sh_sec", sec, 1);

        // Simultaneous key_mode and key_inc edges in SET_MIN.
        press_mode();
        press_inc(5);
        check_val("sm_min5", min, 5);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        step();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        check_val("both_mode", mode, 3);
        check_val("both_min", min, 5);
        step();

        // Held key_inc in SET_SEC gives one increment; blink follows tcnt.
        press_inc(6);
        check_val("ss_sec7", sec, 7);
        key_inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("hold_blink", blink, ((cyc % 4) >= 2) ? 1 : 0);
        end
        key_inc = 1'b0;
        step();
        check_val("hold_sec8", sec, 8);
        check_val("hold_min", min, 5);
        check_val("set_frozen_no_pulse", pulse_seen, 0);
        press_mode();
        check_val("ss_exit_mode", mode, 0);
        check_val("ss_exit_blink", blink, 0);

        // Asynchronous reset in SET_MIN with min=30 and tcnt=2.
        do_reset();
        press_mode();
        press_mode();
        press_inc(30);
        while ((cyc % 4) != 2) step();
        check_val("pre_arst_min", min, 30);
        check_val("pre_arst_mode", mode, 2);
        check_val("pre_arst_blink", blink, 1);
        rst = 1'b1;
        #1;
        check_val("arst_hour", hour, 0);
        check_val("arst_min", min, 0);
        check_val("arst_sec", sec, 0);
        check_val("arst_mode", mode, 0);
        check_val("arst_blink", blink, 0);
        check_val("arst_pulse", sec_pulse, 0);

        // A key held through reset release counts as an edge on the first clock.
        key_mode = 1'b1;
        #1;
        rst = 1'b0;
        cyc = 0;
        step();
        check_val("held_key_edge", mode, 1);
        step();
        check_val("held_key_single", mode, 1);
        key_mode = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
